uart_receiver: RTL and testbench

- Receives 8N1 asynchronous serial data (1 start bit, 8 data bits LSB first, no parity, 1 stop bit) on a single line and delivers each byte in parallel form.
- Signals each new byte with a one-cycle valid strobe.
- Sits at the RX edge of the UART: `i_serial` comes from the pad; the byte and strobe go to the host logic or FIFO.
- Bit timing comes from the system clock through a fixed clocks-per-bit divisor. There is no baud-rate generator input.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_receiver_if.sv | 24 ++
 rtl/uart_sync2.sv | 24 ++
 rtl/uart_receiver.sv | 109 ++++++++++
 tb/tb_uart_receiver.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, frame width and the default
// bit divisor, which the transmitter side reuses.
package uart_pkg;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 217;  // 25 MHz / 115200 baud

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        CLEANUP
    } uart_state_t;

endpackage

// File: rtl/uart_receiver_if.sv
// Parallel-side bundle of the UART receiver: serial line in, byte and strobe out.
interface uart_receiver_if;
    import uart_pkg::*;

    // o_DV is a one-cycle strobe with no back-pressure: the consumer must take
    // o_Byte_parellel in the cycle o_DV is high. The byte then holds until the
    // next accepted frame.
    logic                      i_serial;
    logic                      o_DV;
    logic [UART_DATA_BITS-1:0] o_Byte_parellel;

    modport master (
        input  i_serial,
        output o_DV,
        output o_Byte_parellel
    );

    modport slave (
        output i_serial,
        input  o_DV,
        input  o_Byte_parellel
    );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous RX pad; resets to the idle-high level.
module uart_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling from a fixed clocks-per-bit divisor,
// one-cycle o_DV per accepted byte, framing errors silently dropped.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic            clk,
    input  logic            rst_n,
    uart_receiver_if.master bus,
    output uart_state_t     o_state
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
    localparam int IDX_W = $clog2(UART_DATA_BITS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(UART_DATA_BITS - 1);

    logic                      w_rx_s;
    uart_state_t               r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [IDX_W-1:0]          r_idx;
    logic [UART_DATA_BITS-1:0] r_shift;
    logic                      r_dv;
    logic [UART_DATA_BITS-1:0] r_byte;

    uart_sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (bus.i_serial),
        .o_q   (w_rx_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_dv    <= 1'b0;
            r_byte  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_dv  <= 1'b0;
                    r_cnt <= '0;
                    r_idx <= '0;
                    // The detecting cycle counts as the first of the half bit,
                    // so the start check lands exactly H cycles after it.
                    if (!w_rx_s) begin
                        r_state <= START;
                        r_cnt   <= CNT_ONE;
                    end
                end
                START: begin
                    if (r_cnt == CNT_HALF) begin
                        r_cnt   <= '0;
                        r_state <= w_rx_s ? IDLE : DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                DATA: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt          <= '0;
                        r_shift[r_idx] <= w_rx_s;
                        if (r_idx == IDX_LAST) begin
                            r_state <= STOP;
                        end else begin
                            r_idx <= r_idx + IDX_ONE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                STOP: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_state <= CLEANUP;
                        // A low stop bit is a framing error: keep the old byte.
                        if (w_rx_s) begin
                            r_byte <= r_shift;
                            r_dv   <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                CLEANUP: begin
                    r_dv    <= 1'b0;
                    r_cnt   <= '0;
                    r_idx   <= '0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_DV            = r_dv;
    assign bus.o_Byte_parellel = r_byte;
    assign o_state             = r_state;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: frames driven with real bit times, a
// byte-level expectation queue and hand-computed literal checks.
module tb_uart_receiver;
    import uart_pkg::*;

    localparam int CLK_HALF = 20;
    localparam int BIT_FAST = 8600;
    localparam int BIT_NOM  = 217 * 40;

    logic        clk;
    logic        rst_n;
    uart_state_t w_state;

    uart_receiver_if u_if ();

    uart_receiver #(
        .CLKS_PER_BIT (217)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (u_if),
        .o_state (w_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #(CLK_HALF) clk = ~clk;
    end

    int         checks;
    int         errors;
    int         dv_count;
    logic [7:0] exp_q[$];
    logic [7:0] model_last;
    logic       prev_dv;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver: one 8N1 frame, LSB first. A good stop bit means one byte owed.
    task automatic send_frame(input logic [7:0] b, input logic stop_ok, input int bit_t);
        if (stop_ok) exp_q.push_back(b);
        u_if.i_serial = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            u_if.i_serial = b[i];
            #(bit_t);
        end
        u_if.i_serial = stop_ok;
        #(bit_t);
        u_if.i_serial = 1'b1;
    endtask

    // Scoreboard: every strobe must be single-cycle and carry the oldest owed
    // byte; between strobes the output must hold the last accepted byte.
    initial begin
        model_last = 8'h00;
        prev_dv    = 1'b0;
        dv_count   = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                model_last = 8'h00;
                exp_q.delete();
                prev_dv = 1'b0;
            end else begin
                if (u_if.o_DV) begin
                    dv_count++;
                    checks++;
                    if (prev_dv) begin
                        errors++;
                        $display("FAIL dv_width: o_DV high 2 cycles, expected 1 at %0t", $time);
                    end else if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_dv: byte 0x%0h with nothing owed at %0t",
                                 u_if.o_Byte_parellel, $time);
                    end else begin
                        model_last = exp_q.pop_front();
                    end
                end
                check("byte_hold", {24'd0, u_if.o_Byte_parellel}, {24'd0, model_last});
                prev_dv = u_if.o_DV;
            end
        end
    end

    int lat;

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        u_if.i_serial = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("reset_dv", {31'd0, u_if.o_DV}, 32'd0);
        check("reset_byte", {24'd0, u_if.o_Byte_parellel}, 32'h00);
        check("reset_state", 32'(w_state), 32'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // single frame with a 1% fast transmitter
        send_frame(8'h37, 1'b1, BIT_FAST);
        #(BIT_FAST);
        check("byte_37_after_bit", {24'd0, u_if.o_Byte_parellel}, 32'h37);
        check("dv_count_37", dv_count, 1);

        // back-to-back frames, no idle gap
        send_frame(8'h00, 1'b1, BIT_FAST);
        send_frame(8'hFF, 1'b1, BIT_FAST);
        send_frame(8'hA5, 1'b1, BIT_FAST);
        send_frame(8'h5A, 1'b1, BIT_FAST);
        #(BIT_FAST);
        check("dv_count_b2b", dv_count, 5);
        check("byte_5a", {24'd0, u_if.o_Byte_parellel}, 32'h5A);

        // 50-clock low glitch is rejected at the start-bit check
        @(negedge clk);
        u_if.i_serial = 1'b0;
        repeat (50) @(negedge clk);
        u_if.i_serial = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch_state", 32'(w_state), 32'(IDLE));
        check("glitch_no_dv", dv_count, 5);
        send_frame(8'h3C, 1'b1, BIT_FAST);
        #(BIT_FAST);
        check("byte_3c", {24'd0, u_if.o_Byte_parellel}, 32'h3C);
        check("dv_count_3c", dv_count, 6);

        // framing error: low stop bit
        send_frame(8'h81, 1'b0, BIT_FAST);
        #(2 * BIT_FAST);
        check("frame_err_no_dv", dv_count, 6);
        check("frame_err_keep", {24'd0, u_if.o_Byte_parellel}, 32'h3C);
        check("frame_err_state", 32'(w_state), 32'(IDLE));

        // asynchronous reset in the middle of data bit 4
        @(negedge clk);
        u_if.i_serial = 1'b0;
        #(BIT_NOM);
        for (int i = 0; i < 4; i++) begin
            u_if.i_serial = i[0];
            #(BIT_NOM);
        end
        u_if.i_serial = 1'b0;
        #(BIT_NOM / 2 + 7);
        rst_n = 1'b0;
        #1;
        check("async_rst_dv", {31'd0, u_if.o_DV}, 32'd0);
        check("async_rst_byte", {24'd0, u_if.o_Byte_parellel}, 32'h00);
        check("async_rst_state", 32'(w_state), 32'(IDLE));
        u_if.i_serial = 1'b1;
        repeat (10) @(negedge clk);
        rst_n = 1'b1;
        #(2 * BIT_NOM);
        send_frame(8'hC3, 1'b1, BIT_FAST);
        #(BIT_FAST);
        check("byte_c3", {24'd0, u_if.o_Byte_parellel}, 32'hC3);
        check("dv_count_c3", dv_count, 7);

        // stop-sample latency: H + 9N + 2 = 108 + 1953 + 2 edges after the fall
        @(negedge clk);
        lat = -1;
        fork
            send_frame(8'h96, 1'b1, BIT_NOM);
            begin
                @(posedge clk);
                for (int n = 1; n <= 3000; n++) begin
                    @(posedge clk);
                    #1;
                    if (u_if.o_DV) begin
                        lat = n;
                        break;
                    end
                end
            end
        join
        check("dv_latency", lat, 2063);
        #(BIT_NOM);
        check("byte_96", {24'd0, u_if.o_Byte_parellel}, 32'h96);
        check("dv_count_total", dv_count, 8);
        check("owed_bytes_left", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // hard time limit so the run always ends
    initial begin
        #(20_000_000);
        errors++;
        $display("FAIL timeout: bench did not finish, limit reached at %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
